// File: rtl/ft245_fifo_bridge_pkg.sv
// Shared definitions for the FT245 FIFO bridge.
// Contents:
//   state_t / ST_*          bridge FSM state encoding
//   ARB_RX_PRIO, ARB_RR     values for the ARB_MODE parameter
//   level_w()               bit width of an occupancy counter for a given depth
package ft245_fifo_bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RD    = 3'd1;
  localparam state_t ST_WR_SU = 3'd2;
  localparam state_t ST_WR_P  = 3'd3;
  localparam state_t ST_WR_H  = 3'd4;
  localparam state_t ST_REC   = 3'd5;

  localparam int ARB_RX_PRIO = 0;
  localparam int ARB_RR      = 1;

  // Occupancy 0..depth inclusive needs one bit more than the address.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ft245_fifo_bridge_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write request and data (ignored while full)
//   pop                 read request (ignored while empty)
//   pop_data            head entry, valid whenever !empty
//   full, empty, level  status and occupancy
module sync_fifo
  import ft245_fifo_bridge_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [level_w(DEPTH)-1:0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/ft245_fifo_bridge.sv
// FT245-style asynchronous FIFO bridge.
// Drives the chip's RD#/WR strobes from synchronised RXF#/TXE#/PWR# and
// exposes buffered RX/TX valid/ready byte streams.
// Ports:
//   clk100, rst                      clock, synchronous active-high reset
//   FT_RX_Full_n, FT_TX_Enable_n,    asynchronous chip status (2-flop synced)
//   FT_PWR_n
//   FT_DATA_IN/OUT/OE                pad data bus, OE replicated per bit
//   FT_RD_Strobe_n, FT_WR_Strobe     chip strobes, registered
//   rx_data/valid/ready              RX stream out of the RX buffer
//   tx_data/valid/ready              TX stream into the TX buffer
//   rx_level, tx_level               buffer occupancies
//   ft_online                        synchronised, inverted FT_PWR_n
module ft245_fifo_bridge
  import ft245_fifo_bridge_pkg::*;
#(
  parameter int DW       = 8,
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int RD_PULSE = 6,
  parameter int WR_SETUP = 2,
  parameter int WR_PULSE = 6,
  parameter int WR_HOLD  = 1,
  parameter int RECOVER  = 10,
  parameter int ARB_MODE = ARB_RX_PRIO
) (
  input  logic                          clk100,
  input  logic                          rst,
  input  logic                          FT_RX_Full_n,
  input  logic                          FT_TX_Enable_n,
  input  logic                          FT_PWR_n,
  input  logic [DW-1:0]                 FT_DATA_IN,
  output logic [DW-1:0]                 FT_DATA_OUT,
  output logic [DW-1:0]                 FT_DATA_OE,
  output logic                          FT_RD_Strobe_n,
  output logic                          FT_WR_Strobe,
  output logic [DW-1:0]                 rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic [DW-1:0]                 tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [level_w(RX_DEPTH)-1:0]  rx_level,
  output logic [level_w(TX_DEPTH)-1:0]  tx_level,
  output logic                          ft_online
);

  localparam int CNT_W = 16;

  logic [1:0]       rxf_sync_q, rxf_sync_d;
  logic [1:0]       txe_sync_q, txe_sync_d;
  logic [1:0]       pwr_sync_q, pwr_sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_rd_q, last_rd_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_q, wr_d;
  logic             oe_q, oe_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic [DW-1:0]    rx_byte_q, rx_byte_d;
  logic             rx_push_q, rx_push_d;

  logic             rx_full, rx_empty, tx_full, tx_empty, tx_pop;
  logic [DW-1:0]    tx_head;
  logic             rd_req, wr_req, pick_rd;

  assign ft_online = !pwr_sync_q[1];
  assign rd_req    = ft_online && !rxf_sync_q[1] && !rx_full;
  assign wr_req    = ft_online && !txe_sync_q[1] && !tx_empty;
  // Round-robin picks the side not served last; RX-priority always reads first.
  assign pick_rd   = rd_req && (!wr_req || (ARB_MODE == ARB_RX_PRIO) || !last_rd_q);

  always_comb begin
    rxf_sync_d = {rxf_sync_q[0], FT_RX_Full_n};
    txe_sync_d = {txe_sync_q[0], FT_TX_Enable_n};
    pwr_sync_d = {pwr_sync_q[0], FT_PWR_n};

    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    dout_d    = dout_q;
    rx_byte_d = rx_byte_q;
    rx_push_d = 1'b0;
    tx_pop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_rd) begin
          state_d   = ST_RD;
          cnt_d     = CNT_W'(RD_PULSE - 1);
          last_rd_d = 1'b1;
        end else if (wr_req) begin
          // Byte leaves the TX buffer on WR_SU entry and is held in dout_q.
          state_d   = ST_WR_SU;
          cnt_d     = CNT_W'(WR_SETUP - 1);
          last_rd_d = 1'b0;
          tx_pop    = 1'b1;
          dout_d    = tx_head;
        end
      end
      ST_RD: begin
        if (cnt_q == '0) begin
          state_d   = ST_REC;
          cnt_d     = CNT_W'(RECOVER - 1);
          rx_byte_d = FT_DATA_IN;
          rx_push_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_SU: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_P;
          cnt_d   = CNT_W'(WR_PULSE - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_P: begin
        if (cnt_q == '0) begin
          state_d = ST_WR_H;
          cnt_d   = CNT_W'(WR_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_H: begin
        if (cnt_q == '0) begin
          state_d = ST_REC;
          cnt_d   = CNT_W'(RECOVER - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_REC: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pad strobes are decoded from the next state so the registered outputs
    // change on the same edge the state does. States are exclusive, so RD#
    // low never coincides with WR high or a non-zero OE.
    rd_n_d = (state_d != ST_RD);
    wr_d   = (state_d == ST_WR_P);
    oe_d   = (state_d == ST_WR_SU) || (state_d == ST_WR_P) || (state_d == ST_WR_H);
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      rxf_sync_q <= 2'b11;
      txe_sync_q <= 2'b11;
      pwr_sync_q <= 2'b11;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_rd_q  <= 1'b0;
      rd_n_q     <= 1'b1;
      wr_q       <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      rx_byte_q  <= '0;
      rx_push_q  <= 1'b0;
    end else begin
      rxf_sync_q <= rxf_sync_d;
      txe_sync_q <= txe_sync_d;
      pwr_sync_q <= pwr_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_rd_q  <= last_rd_d;
      rd_n_q     <= rd_n_d;
      wr_q       <= wr_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      rx_byte_q  <= rx_byte_d;
      rx_push_q  <= rx_push_d;
    end
  end

  assign FT_RD_Strobe_n = rd_n_q;
  assign FT_WR_Strobe   = wr_q;
  assign FT_DATA_OUT    = dout_q;
  assign FT_DATA_OE     = {DW{oe_q}};

  sync_fifo #(.DW(DW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk100),
    .rst       (rst),
    .push      (rx_push_q),
    .push_data (rx_byte_q),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  sync_fifo #(.DW(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk100),
    .rst       (rst),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  assign rx_valid = !rx_empty;
  assign tx_ready = !tx_full;

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Directed testbench for ft245_fifo_bridge. Two instances: dut_a uses
// RX-priority arbitration, dut_b round-robin. Each has a small FT chip model
// (byte source for reads, byte sink for writes) and a strobe log.
module tb_ft245_fifo_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwr_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  // ---------------- instance A (ARB_MODE 0) ----------------
  logic       rxf_n_a, txe_n_a = 1'b1, rx_gate_n_a = 1'b1;
  logic [7:0] din_a, dout_a, oe_a, rx_data_a, tx_data_a = '0;
  logic       rd_n_a, wr_a, rx_valid_a, rx_ready_a = 1'b0, tx_valid_a = 1'b0, tx_ready_a, online_a;
  logic [4:0] rx_level_a, tx_level_a;
  logic [7:0] chip_mem_a [64];
  int         chip_wr_a = 0, chip_rd_a = 0;
  logic [7:0] log_a [$];
  logic [7:0] chip_tx_a [$];
  logic       prev_rd_n_a = 1'b1, prev_wr_a = 1'b0;

  assign rxf_n_a = rx_gate_n_a || (chip_rd_a == chip_wr_a);
  assign din_a   = chip_mem_a[chip_rd_a[5:0]];

  ft245_fifo_bridge #(.ARB_MODE(0)) dut_a (
    .clk100(clk), .rst(rst),
    .FT_RX_Full_n(rxf_n_a), .FT_TX_Enable_n(txe_n_a), .FT_PWR_n(pwr_n),
    .FT_DATA_IN(din_a), .FT_DATA_OUT(dout_a), .FT_DATA_OE(oe_a),
    .FT_RD_Strobe_n(rd_n_a), .FT_WR_Strobe(wr_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_level(rx_level_a), .tx_level(tx_level_a), .ft_online(online_a)
  );

  // ---------------- instance B (ARB_MODE 1) ----------------
  logic       rxf_n_b, txe_n_b = 1'b0, rx_gate_n_b = 1'b1;
  logic [7:0] din_b, dout_b, oe_b, rx_data_b, tx_data_b = '0;
  logic       rd_n_b, wr_b, rx_valid_b, rx_ready_b = 1'b1, tx_valid_b = 1'b0, tx_ready_b, online_b;
  logic [4:0] rx_level_b, tx_level_b;
  logic [7:0] chip_mem_b [64];
  int         chip_wr_b = 0, chip_rd_b = 0;
  logic [7:0] log_b [$];
  logic       prev_rd_n_b = 1'b1, prev_wr_b = 1'b0;

  assign rxf_n_b = rx_gate_n_b || (chip_rd_b == chip_wr_b);
  assign din_b   = chip_mem_b[chip_rd_b[5:0]];

  ft245_fifo_bridge #(.ARB_MODE(1)) dut_b (
    .clk100(clk), .rst(rst),
    .FT_RX_Full_n(rxf_n_b), .FT_TX_Enable_n(txe_n_b), .FT_PWR_n(pwr_n),
    .FT_DATA_IN(din_b), .FT_DATA_OUT(dout_b), .FT_DATA_OE(oe_b),
    .FT_RD_Strobe_n(rd_n_b), .FT_WR_Strobe(wr_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_level(rx_level_b), .tx_level(tx_level_b), .ft_online(online_b)
  );

  // Chip models, strobe logs and invariant monitor, all on the falling edge.
  always @(negedge clk) begin
    if (rd_n_a === 1'b0 && prev_rd_n_a === 1'b1) log_a.push_back("R");
    if (rd_n_a === 1'b1 && prev_rd_n_a === 1'b0) chip_rd_a = chip_rd_a + 1;
    if (wr_a === 1'b1 && prev_wr_a === 1'b0) log_a.push_back("W");
    if (wr_a === 1'b0 && prev_wr_a === 1'b1) chip_tx_a.push_back(dout_a);
    prev_rd_n_a = rd_n_a;
    prev_wr_a   = wr_a;
    if (rd_n_b === 1'b0 && prev_rd_n_b === 1'b1) log_b.push_back("R");
    if (rd_n_b === 1'b1 && prev_rd_n_b === 1'b0) chip_rd_b = chip_rd_b + 1;
    if (wr_b === 1'b1 && prev_wr_b === 1'b0) log_b.push_back("W");
    prev_rd_n_b = rd_n_b;
    prev_wr_b   = wr_b;
    if (rst === 1'b0) begin
      if (rd_n_a === 1'b0 && (oe_a !== 8'h00 || wr_a !== 1'b0)) viol = viol + 1;
      if (rd_n_b === 1'b0 && (oe_b !== 8'h00 || wr_b !== 1'b0)) viol = viol + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chip_load_a(input logic [7:0] b);
    chip_mem_a[chip_wr_a[5:0]] = b;
    chip_wr_a = chip_wr_a + 1;
  endtask

  task automatic chip_load_b(input logic [7:0] b);
    chip_mem_b[chip_wr_b[5:0]] = b;
    chip_wr_b = chip_wr_b + 1;
  endtask

  // --------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    pwr_n = 1'b0;
    tick(3);
    n_tests++;
    if ({rd_n_a, wr_a, oe_a, dout_a} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_pads: got rd_n=%b wr=%b oe=%h dout=%h, want 1 0 00 00", rd_n_a, wr_a, oe_a, dout_a);
    end
    n_tests++;
    if ({rx_valid_a, rx_level_a, tx_level_a, online_a} !== {1'b0, 5'd0, 5'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_stream: got rx_valid=%b rx_level=%0d tx_level=%0d online=%b, want 0 0 0 0",
               rx_valid_a, rx_level_a, tx_level_a, online_a);
    end
    rst = 1'b0;
    tick(1);
    n_tests++;
    if ({tx_ready_a, online_a} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_cycle: got tx_ready=%b online=%b, want 1 0", tx_ready_a, online_a);
    end
    tick(1);
    n_tests++;
    if (online_a !== 1'b1) begin
      n_fail++;
      $display("FAIL online_rise: got %b want 1", online_a);
    end
  endtask

  // --------------------------------------------------------------------
  task automatic test_read();
    int c, len, base;
    base = log_a.size();
    chip_load_a(8'hA5);
    tick(1);
    rx_gate_n_a = 1'b0;
    c = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (rd_n_a === 1'b0) begin c = i; break; end
    end
    n_tests++;
    if (c != 3) begin
      n_fail++;
      $display("FAIL rd_latency: got %0d cycles want 3", c);
    end
    len = 1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rd_n_a !== 1'b0) break;
      len++;
    end
    n_tests++;
    if (len != 6) begin
      n_fail++;
      $display("FAIL rd_pulse_len: got %0d want 6", len);
    end
    n_tests++;
    if (rx_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rx_valid_early: got %b want 0", rx_valid_a);
    end
    tick(1);
    n_tests++;
    if ({rx_valid_a, rx_data_a, rx_level_a} !== {1'b1, 8'hA5, 5'd1}) begin
      n_fail++;
      $display("FAIL rx_byte: got valid=%b data=%h level=%0d want 1 a5 1", rx_valid_a, rx_data_a, rx_level_a);
    end
    tick(30);
    n_tests++;
    if (log_a.size() - base != 1) begin
      n_fail++;
      $display("FAIL single_read: got %0d strobes want 1", log_a.size() - base);
    end
    rx_ready_a = 1'b1;
    tick(1);
    rx_ready_a = 1'b0;
    n_tests++;
    if ({rx_valid_a, rx_level_a} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL rx_pop: got valid=%b level=%0d want 0 0", rx_valid_a, rx_level_a);
    end
  endtask

  // --------------------------------------------------------------------
  task automatic test_write();
    logic       tr_oe [80];
    logic       tr_wr [80];
    logic [7:0] tr_d  [80];
    logic [7:0] exp_b [2];
    int         rises [2];
    int         nr, txbase;
    bit         ok_t, ok_d;
    exp_b[0] = 8'h3C;
    exp_b[1] = 8'h7E;
    txe_n_a = 1'b0;
    tick(3);
    txbase = chip_tx_a.size();
    tx_valid_a = 1'b1;
    tx_data_a  = 8'h3C;
    tick(1);
    tr_oe[0] = oe_a[0]; tr_wr[0] = wr_a; tr_d[0] = dout_a;
    tx_data_a = 8'h7E;
    tick(1);
    tx_valid_a = 1'b0;
    for (int i = 1; i < 80; i++) begin
      if (i > 1) tick(1);
      tr_oe[i] = oe_a[0]; tr_wr[i] = wr_a; tr_d[i] = dout_a;
    end
    nr = 0;
    for (int i = 1; i < 80; i++)
      if (tr_wr[i] && !tr_wr[i-1]) begin
        if (nr < 2) rises[nr] = i;
        nr++;
      end
    n_tests++;
    if (nr != 2) begin
      n_fail++;
      $display("FAIL wr_pulse_count: got %0d want 2", nr);
    end else begin
      for (int p = 0; p < 2; p++) begin
        int r;
        r = rises[p];
        ok_t = (r >= 3) && (r + 16 < 80) && !tr_oe[r-3] && tr_oe[r-2] && tr_oe[r-1] && tr_oe[r+6] && !tr_wr[r+6];
        ok_d = 1'b1;
        for (int k = 0; k < 6; k++) if (r + k < 80 && !tr_wr[r+k]) ok_t = 1'b0;
        for (int k = 7; k <= 16; k++) if (r + k < 80 && (tr_oe[r+k] || tr_wr[r+k])) ok_t = 1'b0;
        for (int k = -2; k <= 6; k++) if (r + k < 80 && tr_d[r+k] !== exp_b[p]) ok_d = 1'b0;
        n_tests++;
        if (!ok_t) begin
          n_fail++;
          $display("FAIL wr_timing_%0d: rise at sample %0d, setup/pulse/hold/rec shape wrong, want 2/6/1/10", p, r);
        end
        n_tests++;
        if (!ok_d) begin
          n_fail++;
          $display("FAIL wr_data_%0d: got %h at rise want %h stable over window", p, tr_d[r], exp_b[p]);
        end
      end
    end
    n_tests++;
    if (chip_tx_a.size() - txbase != 2 || chip_tx_a[txbase] !== 8'h3C || chip_tx_a[txbase+1] !== 8'h7E) begin
      n_fail++;
      $display("FAIL wr_chip_bytes: got %0d bytes want 3c 7e", chip_tx_a.size() - txbase);
    end
  endtask

  // --------------------------------------------------------------------
  task automatic test_rx_full();
    int base, n, bad;
    logic [7:0] got [20];
    base = log_a.size();
    rx_ready_a = 1'b0;
    for (int i = 0; i < 20; i++) chip_load_a(8'h40 + 8'(i));
    tick(360);
    n_tests++;
    if (log_a.size() - base != 16) begin
      n_fail++;
      $display("FAIL rx_full_reads: got %0d reads want 16", log_a.size() - base);
    end
    n_tests++;
    if ({rx_level_a, rx_valid_a, rd_n_a} !== {5'd16, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL rx_full_level: got level=%0d valid=%b rd_n=%b want 16 1 1", rx_level_a, rx_valid_a, rd_n_a);
    end
    rx_ready_a = 1'b1;
    n = 0;
    for (int c = 0; c < 700 && n < 20; c++) begin
      if (rx_valid_a) begin got[n] = rx_data_a; n++; end
      tick(1);
    end
    bad = 0;
    for (int i = 0; i < n; i++) if (got[i] !== 8'h40 + 8'(i)) bad++;
    n_tests++;
    if (n != 20 || bad != 0) begin
      n_fail++;
      $display("FAIL rx_drain: got %0d bytes with %0d out of order, want 20 with 0", n, bad);
    end
    n_tests++;
    if (log_a.size() - base != 20) begin
      n_fail++;
      $display("FAIL rx_total_reads: got %0d want 20", log_a.size() - base);
    end
  endtask

  // --------------------------------------------------------------------
  task automatic test_arb_prio();
    int base, txbase;
    string seq;
    base = log_a.size();
    txbase = chip_tx_a.size();
    for (int i = 0; i < 4; i++) chip_load_a(8'h90 + 8'(i));
    tick(5);
    for (int i = 0; i < 4; i++) begin
      tx_valid_a = 1'b1;
      tx_data_a  = 8'hC0 + 8'(i);
      tick(1);
    end
    tx_valid_a = 1'b0;
    tick(200);
    seq = "";
    for (int i = base; i < log_a.size(); i++) seq = {seq, string'(log_a[i])};
    n_tests++;
    if (seq != "RRRRWWWW") begin
      n_fail++;
      $display("FAIL arb_prio_order: got %s want RRRRWWWW", seq);
    end
    n_tests++;
    if (chip_tx_a.size() - txbase != 4 || chip_tx_a[txbase] !== 8'hC0 || chip_tx_a[txbase+3] !== 8'hC3) begin
      n_fail++;
      $display("FAIL arb_prio_bytes: got %0d bytes want c0..c3", chip_tx_a.size() - txbase);
    end
  endtask

  // --------------------------------------------------------------------
  task automatic test_arb_rr();
    int base;
    string seq;
    base = log_b.size();
    for (int i = 0; i < 4; i++) chip_load_b(8'h20 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      tx_valid_b = 1'b1;
      tx_data_b  = 8'hD0 + 8'(i);
      tick(1);
      rx_gate_n_b = 1'b0;
    end
    tx_valid_b = 1'b0;
    tick(220);
    seq = "";
    for (int i = base; i < log_b.size(); i++) seq = {seq, string'(log_b[i])};
    n_tests++;
    if (seq != "WRWRWRWR") begin
      n_fail++;
      $display("FAIL arb_rr_order: got %s want WRWRWRWR", seq);
    end
    n_tests++;
    if ({rx_level_b, tx_level_b} !== {5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL arb_rr_levels: got rx=%0d tx=%0d want 0 0", rx_level_b, tx_level_b);
    end
  endtask

  // --------------------------------------------------------------------
  task automatic test_power();
    int base, txbase, c;
    base = log_a.size();
    txbase = chip_tx_a.size();
    for (int i = 0; i < 4; i++) begin
      tx_valid_a = 1'b1;
      tx_data_a  = 8'hE0 + 8'(i);
      tick(1);
    end
    tx_valid_a = 1'b0;
    c = 0;
    for (int i = 0; i < 30; i++) begin
      if (wr_a === 1'b1) begin c = 1; break; end
      tick(1);
    end
    n_tests++;
    if (c != 1) begin
      n_fail++;
      $display("FAIL pwr_wr_start: WR not seen within 30 cycles");
    end
    tick(2);
    pwr_n = 1'b1;
    tick(100);
    n_tests++;
    if (log_a.size() - base != 1 || tx_level_a !== 5'd3 || online_a !== 1'b0) begin
      n_fail++;
      $display("FAIL pwr_off_hold: got %0d strobes tx_level=%0d online=%b want 1 3 0",
               log_a.size() - base, tx_level_a, online_a);
    end
    pwr_n = 1'b0;
    tick(100);
    n_tests++;
    if (log_a.size() - base != 4 || tx_level_a !== 5'd0) begin
      n_fail++;
      $display("FAIL pwr_resume: got %0d strobes tx_level=%0d want 4 0", log_a.size() - base, tx_level_a);
    end
    n_tests++;
    if (chip_tx_a.size() - txbase != 4 || chip_tx_a[txbase] !== 8'hE0 || chip_tx_a[txbase+3] !== 8'hE3) begin
      n_fail++;
      $display("FAIL pwr_bytes: got %0d bytes want e0..e3", chip_tx_a.size() - txbase);
    end
  endtask

  // --------------------------------------------------------------------
  task automatic test_reset_mid_rd();
    int c;
    txe_n_a = 1'b1;
    tick(3);
    tx_valid_a = 1'b1;
    tx_data_a  = 8'h11;
    tick(1);
    tx_valid_a = 1'b0;
    chip_load_a(8'h5A);
    c = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (rd_n_a === 1'b0) begin c = 1; break; end
    end
    n_tests++;
    if (c != 1 || tx_level_a !== 5'd1) begin
      n_fail++;
      $display("FAIL rst_setup: got rd_seen=%0d tx_level=%0d want 1 1", c, tx_level_a);
    end
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_tests++;
    if ({rd_n_a, wr_a, oe_a, rx_level_a, tx_level_a} !== {1'b1, 1'b0, 8'h00, 5'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_rd: got rd_n=%b wr=%b oe=%h rx=%0d tx=%0d want 1 0 00 0 0",
               rd_n_a, wr_a, oe_a, rx_level_a, tx_level_a);
    end
    rx_gate_n_a = 1'b1;
    tick(30);
    n_tests++;
    if ({rx_valid_a, rx_level_a} !== {1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL rst_no_push: got valid=%b level=%0d want 0 0", rx_valid_a, rx_level_a);
    end
  endtask

  // --------------------------------------------------------------------
  task automatic test_invariants();
    n_tests++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL strobe_invariants: got %0d violating cycles want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_rx_full();
    test_arb_prio();
    test_arb_rr();
    test_power();
    test_reset_mid_rd();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
